// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// ---------------------------------------------------------------------------
// Time-multiplexed scan controller for a bank of common-anode 7-segment
// digits that share one BCD-to-segment decoder. One digit slot lasts 16 scan
// ticks: tick 0 is a dark gap that hides decoder switching (ghosting), ticks
// 1..bright are lit and the rest of the slot stays dark (4-bit PWM). Host data
// is double-buffered and only promoted to the active set at a frame boundary.
//
// Parameters
//   NDIG      number of scanned digits (2..8)
//   PRESCALE  clock cycles per scan tick (>= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          scan enable; low blanks the display and restarts the scan
//   load        one-cycle strobe capturing data/dp_mask/blank_mask/bright
//   data        digit codes, digit i at [4i+3:4i]
//   dp_mask     1 = decimal point lit for digit i
//   blank_mask  1 = digit i never has its anode enabled
//   bright      lit ticks per slot (0..15)
//   an          active-low anode enables, at most one low
//   dec_in      code presented to the shared decoder
//   dp_n        active-low decimal point
//   frame       one-cycle pulse at each frame start
//   load_ack    one-cycle pulse when the shadow set becomes active
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] data,
    input  logic [NDIG-1:0]   dp_mask,
    input  logic [NDIG-1:0]   blank_mask,
    input  logic [3:0]        bright,
    output logic [NDIG-1:0]   an,
    output logic [3:0]        dec_in,
    output logic              dp_n,
    output logic              frame,
    output logic              load_ack
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        ST_GAP,
        ST_ON,
        ST_OFF
    } state_t;

    // scan position
    logic [PW-1:0]     presc_reg, presc_next;
    logic [3:0]        t_reg, t_next;
    logic [IW-1:0]     idx_reg, idx_next;
    state_t            state_reg, state_next;

    // active (displayed) and shadow (host-written) parameter sets
    logic [4*NDIG-1:0] data_act_reg, data_act_next;
    logic [4*NDIG-1:0] data_shd_reg, data_shd_next;
    logic [NDIG-1:0]   dp_act_reg, dp_act_next;
    logic [NDIG-1:0]   dp_shd_reg, dp_shd_next;
    logic [NDIG-1:0]   blank_act_reg, blank_act_next;
    logic [NDIG-1:0]   blank_shd_reg, blank_shd_next;
    logic [3:0]        bright_act_reg, bright_act_next;
    logic [3:0]        bright_shd_reg, bright_shd_next;
    logic              pending_reg, pending_next;

    // registered outputs
    logic [NDIG-1:0]   an_reg, an_next;
    logic [3:0]        dec_reg, dec_next;
    logic              dpn_reg, dpn_next;
    logic              frame_reg, frame_next;
    logic              ack_reg, ack_next;

    logic              tick;
    logic              slot_end;
    logic              frame_end;
    logic              commit;
    logic [3:0]        act_code [NDIG];
    logic [3:0]        shd_code [NDIG];
    logic [NDIG-1:0]   digit_sel;
    logic [NDIG-1:0]   an_lit;
    logic              dpn_lit;

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        assign act_code[gi]  = data_act_reg[4*gi +: 4];
        assign shd_code[gi]  = data_shd_reg[4*gi +: 4];
        assign digit_sel[gi] = (idx_reg == IW'(gi));
    end

    // Anode/DP pattern for the current digit while lit; a blanked digit keeps
    // its anode high even in the ON window.
    assign an_lit  = ~(digit_sel & ~blank_act_reg);
    assign dpn_lit = ~|(digit_sel & dp_act_reg);

    assign tick      = (presc_reg == PW'(PRESCALE - 1));
    assign slot_end  = tick && (t_reg == 4'd15);
    assign frame_end = slot_end && (idx_reg == IW'(NDIG - 1));

    always_comb begin
        presc_next      = presc_reg;
        t_next          = t_reg;
        idx_next        = idx_reg;
        state_next      = state_reg;
        data_act_next   = data_act_reg;
        dp_act_next     = dp_act_reg;
        blank_act_next  = blank_act_reg;
        bright_act_next = bright_act_reg;
        data_shd_next   = data_shd_reg;
        dp_shd_next     = dp_shd_reg;
        blank_shd_next  = blank_shd_reg;
        bright_shd_next = bright_shd_reg;
        pending_next    = pending_reg;
        an_next         = an_reg;
        dec_next        = dec_reg;
        dpn_next        = dpn_reg;
        frame_next      = 1'b0;
        ack_next        = 1'b0;
        commit          = 1'b0;

        if (!en) begin
            presc_next = '0;
            t_next     = '0;
            idx_next   = '0;
            state_next = ST_GAP;
            an_next    = '1;
            dpn_next   = 1'b1;
            dec_next   = act_code[0];
        end else begin
            presc_next = tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                t_next = t_reg + 1'b1;
                case (state_reg)
                    ST_GAP:  state_next = (bright_act_reg != 4'd0) ? ST_ON : ST_OFF;
                    ST_ON:   state_next = (t_next > bright_act_reg) ? ST_OFF : ST_ON;
                    ST_OFF:  state_next = ST_OFF;
                    default: state_next = ST_GAP;
                endcase

                if (slot_end) begin
                    idx_next   = (idx_reg == IW'(NDIG - 1)) ? '0 : idx_reg + 1'b1;
                    state_next = ST_GAP;
                end

                // Promotion happens on the gap edge of digit 0, so the
                // anodes are dark while the active set changes.
                if (frame_end) begin
                    frame_next = 1'b1;
                    if (pending_reg) begin
                        commit          = 1'b1;
                        ack_next        = 1'b1;
                        pending_next    = 1'b0;
                        data_act_next   = data_shd_reg;
                        dp_act_next     = dp_shd_reg;
                        blank_act_next  = blank_shd_reg;
                        bright_act_next = bright_shd_reg;
                    end
                end

                if (state_next == ST_ON) begin
                    an_next  = an_lit;
                    dpn_next = dpn_lit;
                end else begin
                    an_next  = '1;
                    dpn_next = 1'b1;
                end

                // Decoder input only moves on slot entry (gap, anodes dark).
                if (slot_end) begin
                    dec_next = commit ? shd_code[idx_next] : act_code[idx_next];
                end
            end
        end

        // Capture runs regardless of en; a load on the commit edge refills
        // the shadow after its old contents were promoted.
        if (load) begin
            data_shd_next   = data;
            dp_shd_next     = dp_mask;
            blank_shd_next  = blank_mask;
            bright_shd_next = bright;
            pending_next    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg      <= '0;
            t_reg          <= '0;
            idx_reg        <= '0;
            state_reg      <= ST_GAP;
            data_act_reg   <= '0;
            dp_act_reg     <= '0;
            blank_act_reg  <= '1;
            bright_act_reg <= '0;
            data_shd_reg   <= '0;
            dp_shd_reg     <= '0;
            blank_shd_reg  <= '1;
            bright_shd_reg <= '0;
            pending_reg    <= 1'b0;
            an_reg         <= '1;
            dec_reg        <= '0;
            dpn_reg        <= 1'b1;
            frame_reg      <= 1'b0;
            ack_reg        <= 1'b0;
        end else begin
            presc_reg      <= presc_next;
            t_reg          <= t_next;
            idx_reg        <= idx_next;
            state_reg      <= state_next;
            data_act_reg   <= data_act_next;
            dp_act_reg     <= dp_act_next;
            blank_act_reg  <= blank_act_next;
            bright_act_reg <= bright_act_next;
            data_shd_reg   <= data_shd_next;
            dp_shd_reg     <= dp_shd_next;
            blank_shd_reg  <= blank_shd_next;
            bright_shd_reg <= bright_shd_next;
            pending_reg    <= pending_next;
            an_reg         <= an_next;
            dec_reg        <= dec_next;
            dpn_reg        <= dpn_next;
            frame_reg      <= frame_next;
            ack_reg        <= ack_next;
        end
    end

    assign an       = an_reg;
    assign dec_in   = dec_reg;
    assign dp_n     = dpn_reg;
    assign frame    = frame_reg;
    assign load_ack = ack_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl (NDIG=4, PRESCALE=2, 128-cycle frame).
// A behavioural model derives the scan position from the number of enabled
// clock edges since (re)start; the expected outputs for every edge are queued
// and a monitor compares them against the DUT on the following falling edge.
module tb_seg7_scan_ctrl;

    localparam int NDIG     = 4;
    localparam int PRESCALE = 2;
    localparam int FRAME_CY = NDIG * 16 * PRESCALE;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              load = 1'b0;
    logic [4*NDIG-1:0] data = '0;
    logic [NDIG-1:0]   dp_mask = '0;
    logic [NDIG-1:0]   blank_mask = '0;
    logic [3:0]        bright = '0;
    logic [NDIG-1:0]   an;
    logic [3:0]        dec_in;
    logic              dp_n;
    logic              frame;
    logic              load_ack;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data       (data),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .bright     (bright),
        .an         (an),
        .dec_in     (dec_in),
        .dp_n       (dp_n),
        .frame      (frame),
        .load_ack   (load_ack)
    );

    typedef struct packed {
        logic [NDIG-1:0] an;
        logic [3:0]      dec;
        logic            dpn;
        logic            frame;
        logic            ack;
    } obs_t;

    obs_t exp_q[$];
    obs_t last_exp;
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    int              m_k;            // enabled edges since restart
    logic [3:0]      m_act_code [NDIG];
    logic [3:0]      m_shd_code [NDIG];
    logic [NDIG-1:0] m_dp_act, m_dp_shd, m_blank_act, m_blank_shd;
    int              m_bright_act, m_bright_shd;
    bit              m_pend;

    task automatic model_reset();
        m_k = 0;
        for (int i = 0; i < NDIG; i++) begin
            m_act_code[i] = 4'd0;
            m_shd_code[i] = 4'd0;
        end
        m_dp_act = '0;  m_dp_shd = '0;
        m_blank_act = '1; m_blank_shd = '1;
        m_bright_act = 0; m_bright_shd = 0;
        m_pend = 1'b0;
    endtask

    task automatic model_capture();
        for (int i = 0; i < NDIG; i++) m_shd_code[i] = data[4*i +: 4];
        m_dp_shd     = dp_mask;
        m_blank_shd  = blank_mask;
        m_bright_shd = int'(bright);
        m_pend       = 1'b1;
    endtask

    task automatic model_edge(output obs_t e);
        bit frame_p;
        bit ack_p;
        int p, t, idx;
        frame_p = 1'b0;
        ack_p   = 1'b0;
        if (rst) begin
            model_reset();
        end else if (!en) begin
            m_k = 0;
            if (load) model_capture();
        end else begin
            m_k++;
            if ((m_k % PRESCALE) == 0 && ((m_k / PRESCALE) % (16 * NDIG)) == 0) begin
                frame_p = 1'b1;
                if (m_pend) begin
                    for (int i = 0; i < NDIG; i++) m_act_code[i] = m_shd_code[i];
                    m_dp_act     = m_dp_shd;
                    m_blank_act  = m_blank_shd;
                    m_bright_act = m_bright_shd;
                    m_pend       = 1'b0;
                    ack_p        = 1'b1;
                end
            end
            if (load) model_capture();
        end
        p   = m_k / PRESCALE;
        t   = p % 16;
        idx = (p / 16) % NDIG;
        e.an    = '1;
        e.dpn   = 1'b1;
        e.dec   = m_act_code[idx];
        e.frame = frame_p;
        e.ack   = ack_p;
        if (t >= 1 && t <= m_bright_act) begin
            if (!m_blank_act[idx]) e.an[idx] = 1'b0;
            if (m_dp_act[idx])     e.dpn     = 1'b0;
        end
    endtask

    function automatic bit next_is_boundary();
        int kk;
        kk = m_k + 1;
        return en && !rst && (kk % PRESCALE) == 0 && ((kk / PRESCALE) % (16 * NDIG)) == 0;
    endfunction

    function automatic bit at_digit_tick(int want_idx, int want_t);
        int p;
        p = m_k / PRESCALE;
        return ((p / 16) % NDIG) == want_idx && (p % 16) == want_t;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        obs_t e;
        @(posedge clk);
        model_edge(e);
        exp_q.push_back(e);
        last_exp = e;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input logic [4*NDIG-1:0] d, input logic [NDIG-1:0] dp,
                           input logic [NDIG-1:0] bl, input logic [3:0] br);
        data = d; dp_mask = dp; blank_mask = bl; bright = br;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired, got no event, want event within budget", name);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        obs_t got;
        obs_t e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {an, dec_in, dp_n, frame, load_ack};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got an=%b dec=%h dp_n=%b frame=%b ack=%b want an=%b dec=%h dp_n=%b frame=%b ack=%b",
                         $time, got.an, got.dec, got.dpn, got.frame, got.ack,
                         e.an, e.dec, e.dpn, e.frame, e.ack);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int budget;
        model_reset();

        // reset values, then three idle frames (dark, FRAME only)
        rst = 1'b1; en = 1'b1;
        run(3);
        rst = 1'b0;
        run(3 * FRAME_CY);

        // full brightness, DP on digit 2
        do_load(16'h4321, 4'b0100, 4'b0000, 4'd15);
        run(2 * FRAME_CY + 10);

        // partial brightness with digit 1 blanked
        do_load(16'h4321, 4'b0001, 4'b0010, 4'd4);
        run(2 * FRAME_CY);

        // two loads in one frame, third on the commit edge
        do_load(16'h1111, 4'b0000, 4'b0000, 4'd15);
        run(20);
        do_load(16'h9999, 4'b0000, 4'b0000, 4'd15);
        budget = 0;
        while (!next_is_boundary() && budget < 2 * FRAME_CY) begin
            step();
            budget++;
        end
        if (budget >= 2 * FRAME_CY) timeout("wait_commit_edge");
        do_load(16'h5555, 4'b1000, 4'b0000, 4'd15);
        run(2 * FRAME_CY + 4);

        // en dropped mid-slot of digit 2, then restart
        budget = 0;
        while (!at_digit_tick(2, 5) && budget < 2 * FRAME_CY) begin
            step();
            budget++;
        end
        if (budget >= 2 * FRAME_CY) timeout("wait_digit2");
        en = 1'b0;
        run(6);
        en = 1'b1;
        run(FRAME_CY + 40);

        // asynchronous reset while a digit is lit
        budget = 0;
        while (last_exp.an == '1 && budget < FRAME_CY) begin
            step();
            budget++;
        end
        if (budget >= FRAME_CY) timeout("wait_lit");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (an !== '1 || dp_n !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got an=%b dp_n=%b want an=%b dp_n=1", an, dp_n, {NDIG{1'b1}});
        end
        step();
        rst = 1'b0;
        run(FRAME_CY + 20);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            data       = 16'($urandom);
            dp_mask    = 4'($urandom);
            blank_mask = 4'($urandom) & 4'($urandom);
            bright     = 4'($urandom);
            load       = ($urandom_range(0, 49) == 0);
            if (en) begin
                if ($urandom_range(0, 299) == 0) en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                en = 1'b1;
            end
            step();
        end
        load = 1'b0;
        en   = 1'b1;
        run(4);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
